// File: rtl/multi_input_conditioner.sv
// Multi-channel board input conditioner: synchroniser, glitch filter,
// edge pulses, sticky rise flags and rising-edge counters per channel.
module multi_input_conditioner #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       din,
    input  logic [FILT_W-1:0]    filt_len,
    input  logic [NCH-1:0]       clr_sticky,
    output logic [NCH-1:0]       dout,
    output logic [NCH-1:0]       rise,
    output logic [NCH-1:0]       fall,
    output logic [NCH-1:0]       sticky_rise,
    output logic [NCH*CNT_W-1:0] edge_cnt
);

    (* magic_cdc *) logic [NCH-1:0] meta_q;
    logic [NCH-1:0] sync_q [SYNC_STAGES-1];
    logic [NCH-1:0] s;

    logic [FILT_W-1:0] filt_q [NCH];
    logic [CNT_W-1:0]  cnt_q  [NCH];

    logic [NCH-1:0] dout_q;
    logic [NCH-1:0] rise_q;
    logic [NCH-1:0] fall_q;
    logic [NCH-1:0] sticky_q;
    logic [NCH-1:0] commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            for (int k = 0; k < SYNC_STAGES-1; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            meta_q    <= din;
            sync_q[0] <= meta_q;
            for (int k = 1; k < SYNC_STAGES-1; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-2];

    // >= so a lowered threshold commits on the next disagreeing cycle
    always_comb begin
        commit = '0;
        for (int i = 0; i < NCH; i++) begin
            commit[i] = (s[i] != dout_q[i]) && (filt_q[i] >= filt_len);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                filt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (s[i] == dout_q[i] || commit[i]) begin
                    filt_q[i] <= '0;
                end else begin
                    filt_q[i] <= filt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            sticky_q <= '0;
        end else begin
            dout_q   <= (dout_q & ~commit) | (s & commit);
            rise_q   <= commit & s;
            fall_q   <= commit & ~s;
            sticky_q <= rise_q | (sticky_q & ~clr_sticky);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (rise_q[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign dout        = dout_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign sticky_rise = sticky_q;

    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        assign edge_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule
